// File: rtl/sram_controller_if.sv
// Pipeline-side bus of the MEM-stage SRAM controller: one load/store request
// in, the load result and the pipeline freeze signal out.
interface sram_controller_if;
   // Handshake: the pipeline raises wr_en and/or rd_en with address and
   // write_data, then holds all four stable for as long as ready is 0.
   // The cycle in which ready is 1 again (DONE) completes the transfer.
   // read_data is valid from that cycle until the next load overwrites it.
   logic        wr_en;
   logic        rd_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;

   modport master (
      output wr_en, rd_en, address, write_data,
      input  read_data, ready
   );

   modport slave (
      input  wr_en, rd_en, address, write_data,
      output read_data, ready
   );
endinterface

// File: rtl/sram_controller.sv
// MEM-stage data memory sequencer: one 32-bit load/store becomes two 16-bit
// SRAM accesses (low half, then high half) while ready holds the pipeline.
module sram_controller #(
   parameter int WAIT_CYCLES = 1,
   parameter int ADDR_BASE   = 1024,
   parameter int SRAM_ADDR_W = 18
) (
   input  logic                   clk,
   input  logic                   rst,
   sram_controller_if.slave       bus,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [15:0]            sram_dq_out,
   input  logic [15:0]            sram_dq_in,
   output logic                   sram_dq_oe,
   output logic                   sram_we_n,
   output logic [1:0]             state_dbg
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACC_LO = 2'd1;
   localparam logic [1:0] ACC_HI = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

   logic [1:0]             state;
   logic [CNT_W-1:0]       counter;
   logic [SRAM_ADDR_W-2:0] word_q;
   logic [15:0]            data_hi_q;
   logic                   write_q;
   logic [31:0]            read_data_q;
   logic [31:0]            offset;
   logic [SRAM_ADDR_W-2:0] word_next;
   logic                   req;
   logic                   half_done;

   assign req       = bus.wr_en | bus.rd_en;
   // Addresses below ADDR_BASE wrap modulo 2^32 and are then truncated.
   assign offset    = bus.address - 32'(ADDR_BASE);
   assign word_next = (SRAM_ADDR_W-1)'(offset >> 2);
   assign half_done = (counter == CNT_LAST);

   assign bus.ready     = (state == DONE) || ((state == IDLE) && !req);
   assign bus.read_data = read_data_q;
   assign state_dbg     = state;

   // SRAM pins are registered on the transition into each phase, so they
   // line up with the state and never follow the request inputs directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         counter     <= '0;
         word_q      <= '0;
         data_hi_q   <= '0;
         write_q     <= 1'b0;
         read_data_q <= '0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  state     <= ACC_LO;
                  counter   <= '0;
                  word_q    <= word_next;
                  data_hi_q <= bus.write_data[31:16];
                  write_q   <= bus.wr_en;
                  sram_addr <= {word_next, 1'b0};
                  if (bus.wr_en) begin
                     sram_dq_out <= bus.write_data[15:0];
                  end
                  sram_dq_oe <= bus.wr_en;
                  sram_we_n  <= ~bus.wr_en;
               end
            end
            ACC_LO: begin
               if (half_done) begin
                  state     <= ACC_HI;
                  counter   <= '0;
                  sram_addr <= {word_q, 1'b1};
                  if (write_q) begin
                     sram_dq_out <= data_hi_q;
                  end else begin
                     read_data_q[15:0] <= sram_dq_in;
                  end
               end else begin
                  counter <= counter + CNT_W'(1);
               end
            end
            ACC_HI: begin
               if (half_done) begin
                  state      <= DONE;
                  sram_dq_oe <= 1'b0;
                  sram_we_n  <= 1'b1;
                  if (!write_q) begin
                     read_data_q[31:16] <= sram_dq_in;
                  end
               end else begin
                  counter <= counter + CNT_W'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sram_controller.sv
// Randomized scoreboard bench for sram_controller: a 16-bit SRAM model with a
// minimum write-pulse rule, a half-word reference memory, and a pin monitor.
`timescale 1ns/1ps
module tb_sram_controller;
   localparam int WAIT = 1;
   localparam int N    = WAIT + 1;
   localparam int BASE = 1024;
   localparam int AW   = 18;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- DUT with WAIT_CYCLES=1 ----------------
   sram_controller_if bus();
   logic [AW-1:0] sram_addr;
   logic [15:0]   sram_dq_out;
   logic [15:0]   sram_dq_in;
   logic          sram_dq_oe;
   logic          sram_we_n;
   logic [1:0]    state_dbg;

   sram_controller #(.WAIT_CYCLES(WAIT), .ADDR_BASE(BASE), .SRAM_ADDR_W(AW)) u_dut (
      .clk(clk), .rst(rst), .bus(bus),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
      .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .state_dbg(state_dbg)
   );

   // ---------------- DUT with WAIT_CYCLES=0 ----------------
   sram_controller_if bus0();
   logic [AW-1:0] sram_addr0;
   logic [15:0]   sram_dq_out0;
   logic [15:0]   sram_dq_in0;
   logic          sram_dq_oe0;
   logic          sram_we_n0;
   logic [1:0]    state_dbg0;

   sram_controller #(.WAIT_CYCLES(0), .ADDR_BASE(BASE), .SRAM_ADDR_W(AW)) u_dut_w0 (
      .clk(clk), .rst(rst), .bus(bus0),
      .sram_addr(sram_addr0), .sram_dq_out(sram_dq_out0), .sram_dq_in(sram_dq_in0),
      .sram_dq_oe(sram_dq_oe0), .sram_we_n(sram_we_n0), .state_dbg(state_dbg0)
   );

   // ---------------- SRAM models ----------------
   // A half is stored only after we_n has been low for N cycles on the same
   // address and data, so a write cut short by reset leaves memory untouched.
   logic [15:0]   sram_mem [0:(1<<AW)-1];
   int            wr_run = 0;
   logic [AW-1:0] run_addr;
   logic [15:0]   run_data;
   assign sram_dq_in = sram_mem[sram_addr];

   always @(posedge clk) begin : sram_model
      int run;
      if (!sram_we_n) begin
         run = (wr_run > 0 && sram_addr == run_addr && sram_dq_out == run_data) ? wr_run + 1 : 1;
         wr_run   <= run;
         run_addr <= sram_addr;
         run_data <= sram_dq_out;
         if (run == N) sram_mem[sram_addr] <= sram_dq_out;
      end else begin
         wr_run <= 0;
      end
   end

   logic [15:0] mem0 [0:15];
   assign sram_dq_in0 = mem0[sram_addr0[3:0]];
   always @(posedge clk) begin
      if (!sram_we_n0) mem0[sram_addr0[3:0]] <= sram_dq_out0;
   end

   // ---------------- reference model and scoreboard ----------------
   typedef struct packed {
      logic          wr;
      logic [AW-1:0] lo;
      logic [31:0]   data;
      logic [31:0]   rd;
   } exp_t;
   localparam int EXP_W = $bits(exp_t);

   logic [EXP_W-1:0] exp_q[$];
   logic [15:0]      ref_mem [logic [AW-1:0]];
   logic [31:0]      drv_rd = 32'h0;
   int               n_cmp = 0;
   int               n_err = 0;
   bit               mon_en = 1'b0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic logic [AW-1:0] half_lo(logic [31:0] a);
      logic [31:0] w;
      w = (a - 32'(BASE)) >> 2;
      return AW'((w % (32'd1 << (AW-1))) * 32'd2);
   endfunction

   function automatic logic [15:0] ref_rd(logic [AW-1:0] h);
      return ref_mem.exists(h) ? ref_mem[h] : 16'h0;
   endfunction

   // ---------------- driver ----------------
   // Called at posedge+1; returns at posedge+1 of the cycle after DONE.
   task automatic access(bit wr, bit rd, logic [31:0] a, logic [31:0] d, bit garble);
      exp_t e;
      logic [AW-1:0] h;
      int budget;
      h = half_lo(a);
      e.wr   = wr;
      e.lo   = h;
      e.data = d;
      if (wr) begin
         ref_mem[h]        = d[15:0];
         ref_mem[h + 1'b1] = d[31:16];
      end else if (rd) begin
         drv_rd = {ref_rd(h + 1'b1), ref_rd(h)};
      end
      e.rd = drv_rd;
      exp_q.push_back(e);
      bus.wr_en = wr;
      bus.rd_en = rd;
      bus.address = a;
      bus.write_data = d;
      budget = 0;
      @(negedge clk);
      while (!bus.ready && budget < 4*N + 8) begin
         @(posedge clk); #1;
         if (garble) begin
            bus.address = $urandom;
            bus.write_data = $urandom;
         end
         @(negedge clk);
         budget++;
      end
      if (!bus.ready) check("stall_timeout", 64'(0), 64'(1));
      @(posedge clk); #1;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
   endtask

   task automatic idle(int cycles);
      repeat (cycles) begin
         @(posedge clk); #1;
      end
   endtask

   // ---------------- monitor ----------------
   int            k = 0;
   bit            in_acc = 1'b0;
   exp_t          cur;
   logic [31:0]   mon_rd = 32'h0;
   logic [AW-1:0] exp_addr;
   logic [15:0]   exp_dq;

   initial forever begin
      @(negedge clk);
      if (rst) begin
         in_acc = 1'b0;
         k = 0;
         mon_rd = 32'h0;
      end else if (mon_en) begin
         if (!bus.ready) begin
            if (!in_acc) begin
               in_acc = 1'b1;
               k = 0;
               if (exp_q.size() == 0) begin
                  check("unexpected_access", 64'(1), 64'(0));
                  cur = '0;
               end else begin
                  cur = exp_q[0];
               end
            end else begin
               k++;
            end
            if (k == 0) begin
               check("req_cycle_pins", 64'({sram_we_n, sram_dq_oe}), 64'(2'b10));
            end else if (k <= 2*N) begin
               exp_addr = cur.lo + AW'(k > N);
               exp_dq   = (k > N) ? cur.data[31:16] : cur.data[15:0];
               if (cur.wr)
                  check("write_pins", 64'({sram_addr, sram_we_n, sram_dq_oe, sram_dq_out}),
                        64'({exp_addr, 1'b0, 1'b1, exp_dq}));
               else
                  check("read_pins", 64'({sram_addr, sram_we_n, sram_dq_oe}),
                        64'({exp_addr, 1'b1, 1'b0}));
            end else begin
               check("stall_too_long", 64'(k), 64'(2*N));
            end
         end else if (in_acc) begin
            check("stall_len", 64'(k + 1), 64'(1 + 2*N));
            check("done_read_data", 64'(bus.read_data), 64'(cur.rd));
            check("done_pins", 64'({sram_we_n, sram_dq_oe}), 64'(2'b10));
            mon_rd = cur.rd;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            in_acc = 1'b0;
         end else begin
            check("idle_pins_data", 64'({sram_we_n, sram_dq_oe, bus.read_data}),
                  64'({1'b1, 1'b0, mon_rd}));
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] old9;
      int low;
      foreach (sram_mem[i]) sram_mem[i] <= 16'h0;
      foreach (mem0[i]) mem0[i] <= 16'h0;
      rst = 1'b1;
      bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.address = '0; bus.write_data = '0;
      bus0.wr_en = 1'b0; bus0.rd_en = 1'b0; bus0.address = '0; bus0.write_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ready", 64'(bus.ready), 64'(1));
      check("reset_read_data", 64'(bus.read_data), 64'(0));
      check("reset_pins", 64'({sram_we_n, sram_dq_oe, sram_addr, sram_dq_out}),
            64'({1'b1, 1'b0, 18'd0, 16'h0}));
      @(posedge clk); #1;
      rst = 1'b0;
      mon_en = 1'b1;

      // Directed: store, load, idle, back-to-back store/load, dual enable.
      access(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 1'b0);
      access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0);
      idle(10);
      access(1'b1, 1'b0, 32'd1036, 32'h12345678, 1'b0);
      access(1'b0, 1'b1, 32'd1036, 32'h0, 1'b0);
      access(1'b1, 1'b1, 32'd1024, 32'hCAFEF00D, 1'b0);
      check("sram_word0_lo", 64'(sram_mem[0]), 64'(16'hF00D));
      check("sram_word0_hi", 64'(sram_mem[1]), 64'(16'hCAFE));
      check("sram_word1_lo", 64'(sram_mem[4]), 64'(16'hBEEF));

      // Randomized mix, including wrapped addresses and mid-access input noise.
      for (int i = 0; i < 60; i++) begin
         int op;
         logic [31:0] a;
         op = $urandom_range(0, 3);
         if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 1023);
         else a = 32'd1024 + $urandom_range(0, 127);
         access(op == 1 || op == 2, op != 1, a, $urandom, 1'($urandom_range(0, 1)));
         idle($urandom_range(0, 2));
      end
      access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0);

      // Reset during the first ACC_HI cycle of a store to 1040.
      mon_en = 1'b0;
      old9 = ref_rd(18'd9);
      bus.wr_en = 1'b1; bus.address = 32'd1040; bus.write_data = 32'hAAAA5555;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("pre_reset_hi_pins", 64'({sram_addr, sram_we_n, sram_dq_out}),
            64'({18'd9, 1'b0, 16'hAAAA}));
      rst = 1'b1;
      bus.wr_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_ready", 64'(bus.ready), 64'(1));
      check("post_reset_read_data", 64'(bus.read_data), 64'(0));
      check("post_reset_pins", 64'({sram_we_n, sram_dq_oe, sram_addr, sram_dq_out}),
            64'({1'b1, 1'b0, 18'd0, 16'h0}));
      check("partial_write_lo", 64'(sram_mem[8]), 64'(16'h5555));
      check("partial_write_hi", 64'(sram_mem[9]), 64'(old9));
      ref_mem[18'd8] = 16'h5555;
      drv_rd = 32'h0;
      @(posedge clk); #1;
      mon_en = 1'b1;
      access(1'b0, 1'b1, 32'd1040, 32'h0, 1'b0);
      idle(2);

      // WAIT_CYCLES=0 instance: dual enable acts as a 3-cycle write.
      bus0.wr_en = 1'b1; bus0.rd_en = 1'b1; bus0.address = 32'd1024; bus0.write_data = 32'hCAFEF00D;
      low = 0;
      @(negedge clk);
      while (!bus0.ready && low < 20) begin
         low++;
         @(negedge clk);
      end
      check("w0_write_stall_len", 64'(low), 64'(3));
      check("w0_read_data_kept", 64'(bus0.read_data), 64'(0));
      @(posedge clk); #1;
      bus0.wr_en = 1'b0; bus0.rd_en = 1'b0;
      check("w0_mem_lo", 64'(mem0[0]), 64'(16'hF00D));
      check("w0_mem_hi", 64'(mem0[1]), 64'(16'hCAFE));
      bus0.rd_en = 1'b1;
      low = 0;
      @(negedge clk);
      while (!bus0.ready && low < 20) begin
         low++;
         @(negedge clk);
      end
      check("w0_read_stall_len", 64'(low), 64'(3));
      check("w0_read_data", 64'(bus0.read_data), 64'(32'hCAFEF00D));
      @(posedge clk); #1;
      bus0.rd_en = 1'b0;
      idle(2);

      check("queue_drained", 64'(exp_q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
